warp_fetcher: RTL and testbench
===============================

// Module: warp_fetcher
// PURPOSE
//  Per-warp instruction fetch unit: supplies the 32-bit instr word that the decoder latches in WARP_DECODE.
//  While warp_state == WARP_FETCH it requests the word at pc from the program-memory controller over a
//  valid/ready request channel and a valid-only response channel.
//  It holds the word stable and reports completion through fetch_state.
//  An optional one-entry last-PC buffer skips memory when the same pc is refetched (e.g. a branch to self).
// PARAMETERS
//  ADDR_W    32  width of pc and mem_req_addr
//  BUF_EN    1   1 = enable the last-PC buffer; 0 = every fetch goes to memory
// PORTS
//  clk             in   1        clock; all state updates on posedge
//  reset           in   1        synchronous, active-high
//  warp_state      in   warp_state_t  current warp state from the warp scheduler
//  pc              in   ADDR_W   address to fetch; stable while warp_state == WARP_FETCH
//  mem_req_valid   out  1        read request valid
//  mem_req_addr    out  ADDR_W   read address; equals the pc captured at request start
//  mem_req_ready   in   1        controller accepts the request this cycle when valid&&ready
//  mem_rsp_valid   in   1        one-cycle pulse; response data valid
//  mem_rsp_data    in   instr_t  instruction word
//  fetch_state     out  fetch_state_t  FETCH_IDLE / FETCH_REQ / FETCH_WAIT / FETCH_DONE
//  instr           out  instr_t  fetched word presented to the decoder
// BEHAVIOUR
//  Reset values: fetch_state=FETCH_IDLE, mem_req_valid=0, mem_req_addr=0, instr=0, buf_valid=0, abandon=0.
//   instr=0 decodes as HALT, which is a safe value.
//  The memory controller shares this reset, so no response is ever in flight across a reset.
//  FSM, one transition per clk:
//  - IDLE -> DONE if warp_state==WARP_FETCH, BUF_EN, buf_valid and pc==buf_pc: instr=buf_instr, no request.
//  - IDLE -> REQ if warp_state==WARP_FETCH otherwise: capture pc into mem_req_addr, set mem_req_valid=1.
//  - REQ: hold mem_req_valid/addr constant until accepted.
//    - On valid&&ready: go to WAIT and drop mem_req_valid the next cycle.
//    - If warp_state leaves WARP_FETCH before acceptance: drop the request and go to IDLE (abort).
//  - WAIT: on mem_rsp_valid, load instr and buf_instr/buf_pc/buf_valid=1, then go to DONE.
//    - If warp_state left WARP_FETCH during WAIT: set abandon=1 and keep waiting.
//    - An abandoned response is absorbed without touching instr or the buffer, and the FSM goes to IDLE.
//  - DONE: stay while warp_state==WARP_FETCH; go to IDLE when it changes (scheduler moves to WARP_DECODE).
//  mem_rsp_valid in IDLE/REQ/DONE: illegal; ignored and flagged by an assertion.
//  Response may arrive in the cycle right after acceptance (min latency); ready may be high in the first REQ cycle.
//  Latency pc->DONE: buffer hit = 1 clk.
//   Miss with ready=1 and 1-cycle response = 3 clk (IDLE->REQ->WAIT->DONE).
//  instr changes only on a non-abandoned response or a buffer hit.
//   It holds through WARP_DECODE and later states until the next fetch completes.
//  Reset asserted in any state returns to IDLE next clk with all reset values; buffer invalidated.
//  BUF_EN=0: buf_* registers are tied off, and IDLE always goes to REQ.
//  Only one outstanding request; no new request while in WAIT.
// STRUCTURE
//  common_pkg: add fetch_state_t enum (FETCH_IDLE, FETCH_REQ, FETCH_WAIT, FETCH_DONE).
//   Reuse warp_state_t, instr_t and data_t already in common_pkg.
//  No sub-module; FSM plus buffer registers in one always_ff with a separate next-state always_comb.
// TESTING
//  1 Reset then warp_state=WARP_FETCH, pc=0x40, ready=1, rsp 1 clk after accept with data 0x00500093:
//    -> req_addr=0x40, one accepted request, FETCH_DONE on 3rd clk, instr=0x00500093.
//  2 Repeat fetch of pc=0x40 (BUF_EN=1) -> no mem_req_valid, FETCH_DONE after 1 clk, instr=0x00500093.
//    Same case with BUF_EN=0 -> full request cycle.
//  3 ready held low 5 clks at pc=0x44 -> mem_req_valid and addr 0x44 stable all 5 clks.
//    Accept on 6th clk; a single request only.
//  4 warp_state leaves WARP_FETCH while in WAIT, rsp 0xDEADBEEF arrives -> FSM to IDLE.
//    instr keeps its old value; a next fetch of the same pc is not a buffer hit.
//  5 reset pulsed in REQ and again in WAIT -> next clk FETCH_IDLE, mem_req_valid=0, instr=0.
//    A following fetch of 0x40 misses the buffer.
//  6 Abort in REQ (warp_state drops before ready) -> mem_req_valid low next clk, no response expected.
//    FSM in IDLE.

Source files
------------

// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common_pkg
// Description : Shared warp-pipeline types: warp scheduler states,
//               instruction/data words and instruction-fetch states.
// Revision    : 1.0 - initial release with fetch_state_t
// ============================================================================
package common_pkg;

  // Warp scheduler state as broadcast to per-warp pipeline units
  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_EXECUTE = 3'd3,
    WARP_MEM     = 3'd4,
    WARP_DONE    = 3'd5
  } warp_state_t;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] data_t;

  // Instruction fetch progress reported to the scheduler
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_DONE = 2'd3
  } fetch_state_t;

  // All-zero word decodes as HALT, so it is the safe post-reset instruction
  localparam instr_t C_INSTR_HALT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/warp_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : warp_fetcher
// Description : Per-warp instruction fetch unit. Issues one valid/ready read
//               request per fetch, waits for a valid-only response, holds the
//               fetched word for the decoder, and optionally short-circuits
//               refetches of the last completed pc through a one-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module warp_fetcher
  import common_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter bit BUF_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  warp_state_t       warp_state,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  instr_t            mem_rsp_data,
  output fetch_state_t      fetch_state,
  output instr_t            instr
);

  fetch_state_t      state_q,     state_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_addr_q,  req_addr_d;
  instr_t            instr_q,     instr_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_pc_q,    buf_pc_d;
  instr_t            buf_instr_q, buf_instr_d;
  // Set once the scheduler has walked away from an accepted request; the
  // eventual response must then be swallowed without side effects.
  logic              abandon_q,   abandon_d;

  logic w_in_fetch;
  logic w_buf_hit;

  assign w_in_fetch = (warp_state == WARP_FETCH);
  assign w_buf_hit  = BUF_EN && buf_valid_q && (pc == buf_pc_q);

  // Next-state and datapath update for the fetch FSM and the last-pc buffer
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    instr_d     = instr_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    abandon_d   = abandon_q;

    case (state_q)
      FETCH_IDLE: begin
        if (w_in_fetch) begin
          if (w_buf_hit) begin
            state_d = FETCH_DONE;
            instr_d = buf_instr_q;
          end else begin
            state_d     = FETCH_REQ;
            req_valid_d = 1'b1;
            req_addr_d  = pc;
            abandon_d   = 1'b0;
          end
        end
      end
      FETCH_REQ: begin
        // A handshake in the same cycle the scheduler leaves still commits
        // the request, so it wins over the abort and is marked abandoned.
        if (req_valid_q && mem_req_ready) begin
          state_d     = FETCH_WAIT;
          req_valid_d = 1'b0;
          abandon_d   = !w_in_fetch;
        end else if (!w_in_fetch) begin
          state_d     = FETCH_IDLE;
          req_valid_d = 1'b0;
        end
      end
      FETCH_WAIT: begin
        if (mem_rsp_valid) begin
          if (abandon_q || !w_in_fetch) begin
            state_d   = FETCH_IDLE;
            abandon_d = 1'b0;
          end else begin
            state_d     = FETCH_DONE;
            instr_d     = mem_rsp_data;
            buf_valid_d = 1'b1;
            buf_pc_d    = req_addr_q;
            buf_instr_d = mem_rsp_data;
          end
        end else if (!w_in_fetch) begin
          abandon_d = 1'b1;
        end
      end
      FETCH_DONE: begin
        if (!w_in_fetch) begin
          state_d = FETCH_IDLE;
        end
      end
      default: begin
        state_d     = FETCH_IDLE;
        req_valid_d = 1'b0;
      end
    endcase

    // Without the buffer its registers stay constant zero
    if (!BUF_EN) begin
      buf_valid_d = 1'b0;
      buf_pc_d    = '0;
      buf_instr_d = '0;
    end
  end

  // State register with synchronous reset; reset also invalidates the buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH_IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      instr_q     <= C_INSTR_HALT;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
      abandon_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      instr_q     <= instr_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      abandon_q   <= abandon_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign fetch_state   = state_q;
  assign instr         = instr_q;

  // A response is only legal while a request is outstanding
  a_rsp_only_in_wait : assert property (
    @(posedge clk) disable iff (reset)
    mem_rsp_valid |-> (state_q == FETCH_WAIT)
  );

endmodule
`default_nettype wire

// File: tb/tb_warp_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_warp_fetcher
// Description : Self-checking bench for warp_fetcher. Drives the buffered and
//               unbuffered variants from one stimulus stream and checks both
//               against a transaction-level model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_warp_fetcher;
  import common_pkg::*;

  localparam int AW = 32;

  logic clk = 1'b0;
  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  logic          reset;
  warp_state_t   warp_state;
  logic [AW-1:0] pc;
  logic          ready;
  logic          rsp_valid;
  instr_t        rsp_data;

  logic          v0, v1;
  logic [AW-1:0] a0, a1;
  fetch_state_t  s0, s1;
  instr_t        i0, i1;

  warp_fetcher #(.ADDR_W(AW), .BUF_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .warp_state(warp_state), .pc(pc),
    .mem_req_valid(v0), .mem_req_addr(a0), .mem_req_ready(ready),
    .mem_rsp_valid(rsp_valid), .mem_rsp_data(rsp_data),
    .fetch_state(s0), .instr(i0)
  );

  warp_fetcher #(.ADDR_W(AW), .BUF_EN(1'b0)) u_dut_nobuf (
    .clk(clk), .reset(reset), .warp_state(warp_state), .pc(pc),
    .mem_req_valid(v1), .mem_req_addr(a1), .mem_req_ready(ready),
    .mem_rsp_valid(rsp_valid), .mem_rsp_data(rsp_data),
    .fetch_state(s1), .instr(i1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;

  // Reference model: last completed fetch (buffer contents) and the word each
  // decoder should currently see.
  logic          m_valid;
  logic [AW-1:0] m_pc;
  instr_t        m_instr;
  instr_t        exp_i0, exp_i1;

  // Count accepted requests of the buffered unit
  always @(posedge clk) begin
    if (!reset && v0 && ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    warp_state = WARP_DECODE;
    ready      = 1'b0;
    rsp_valid  = 1'b0;
    tick();
    chk("rst_state",  s0, FETCH_IDLE);
    chk("rst_valid",  v0, 1'b0);
    chk("rst_addr",   a0, '0);
    chk("rst_instr",  i0, '0);
    chk("rst_state1", s1, FETCH_IDLE);
    chk("rst_instr1", i1, '0);
    reset   = 1'b0;
    m_valid = 1'b0;
    exp_i0  = '0;
    exp_i1  = '0;
  endtask

  // One fetch episode. mode 0: normal, 1: abort in REQ, 2: abandon in WAIT.
  // rdly: cycles ready stays low in REQ; sdly: extra cycles before response.
  task automatic fetch(input logic [AW-1:0] addr, input int rdly, input int sdly,
                       input instr_t data, input int mode);
    bit hit;
    int acc0;
    hit  = m_valid && (m_pc == addr);
    acc0 = acc_cnt;
    warp_state = WARP_FETCH;
    pc         = addr;
    ready      = 1'b0;
    rsp_valid  = 1'b0;
    tick();
    chk("nobuf_req_state", s1, FETCH_REQ);
    chk("nobuf_req_valid", v1, 1'b1);
    if (hit) begin
      chk("hit_state",  s0, FETCH_DONE);
      chk("hit_no_req", v0, 1'b0);
      exp_i0 = m_instr;
      chk("hit_instr",  i0, exp_i0);
      warp_state = WARP_DECODE;
      tick();
      chk("hit_idle",          s0, FETCH_IDLE);
      chk("hit_instr_hold",    i0, exp_i0);
      chk("nobuf_abort_idle",  s1, FETCH_IDLE);
      chk("nobuf_abort_valid", v1, 1'b0);
      chk("nobuf_instr",       i1, exp_i1);
      chk("hit_no_accept",     acc_cnt, acc0);
      return;
    end
    chk("req_state", s0, FETCH_REQ);
    chk("req_valid", v0, 1'b1);
    chk("req_addr",  a0, addr);
    for (int k = 0; k < rdly; k++) begin
      tick();
      chk("req_hold_state", s0, FETCH_REQ);
      chk("req_hold_valid", v0, 1'b1);
      chk("req_hold_addr",  a0, addr);
    end
    if (mode == 1) begin
      warp_state = WARP_DECODE;
      tick();
      chk("abort_state",  s0, FETCH_IDLE);
      chk("abort_valid",  v0, 1'b0);
      chk("abort_state1", s1, FETCH_IDLE);
      repeat (2) begin
        tick();
        chk("abort_quiet", v0, 1'b0);
      end
      chk("abort_instr",  i0, exp_i0);
      chk("abort_no_acc", acc_cnt, acc0);
      return;
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("wait_state", s0, FETCH_WAIT);
    chk("wait_valid", v0, 1'b0);
    chk("accepted",   acc_cnt, acc0 + 1);
    if (mode == 2) warp_state = WARP_DECODE;
    for (int k = 0; k < sdly; k++) begin
      tick();
      chk("wait_hold", s0, FETCH_WAIT);
    end
    rsp_valid = 1'b1;
    rsp_data  = data;
    tick();
    rsp_valid = 1'b0;
    if (mode == 2) begin
      chk("abandon_idle",   s0, FETCH_IDLE);
      chk("abandon_instr",  i0, exp_i0);
      chk("abandon_instr1", i1, exp_i1);
    end else begin
      exp_i0  = data;
      exp_i1  = data;
      m_valid = 1'b1;
      m_pc    = addr;
      m_instr = data;
      chk("done_state",  s0, FETCH_DONE);
      chk("done_instr",  i0, exp_i0);
      chk("done_state1", s1, FETCH_DONE);
      chk("done_instr1", i1, exp_i1);
      tick();
      chk("done_stays",  s0, FETCH_DONE);
      warp_state = WARP_DECODE;
      tick();
      chk("done_to_idle", s0, FETCH_IDLE);
      chk("instr_hold",   i0, exp_i0);
    end
    chk("single_req", acc_cnt, acc0 + 1);
  endtask

  // Main stimulus sequence
  initial begin
    int r, mode;
    reset      = 1'b1;
    warp_state = WARP_DECODE;
    pc         = '0;
    ready      = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    m_valid    = 1'b0;
    m_pc       = '0;
    m_instr    = '0;
    exp_i0     = '0;
    exp_i1     = '0;
    tick();
    do_reset();

    // Basic miss, then buffered refetch of the same pc
    fetch(32'h40, 0, 0, 32'h0050_0093, 0);
    fetch(32'h40, 0, 0, 32'h0, 0);
    // Back-pressure held for five cycles
    fetch(32'h44, 5, 0, 32'h0010_0113, 0);
    // Abandon in WAIT, then the same pc must still miss
    fetch(32'h48, 0, 1, 32'hDEAD_BEEF, 2);
    fetch(32'h48, 0, 0, 32'h0020_0193, 0);
    // Abort in REQ
    fetch(32'h4C, 2, 0, 32'h0, 1);

    // Reset while in REQ
    warp_state = WARP_FETCH;
    pc         = 32'h40;
    tick();
    chk("pre_rst_req", s0, FETCH_REQ);
    do_reset();
    // Reset while in WAIT (no response follows)
    warp_state = WARP_FETCH;
    pc         = 32'h40;
    ready      = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    chk("pre_rst_wait", s0, FETCH_WAIT);
    do_reset();
    fetch(32'h40, 0, 0, 32'h0050_0093, 0);

    // Randomized episodes
    for (int e = 0; e < 60; e++) begin
      r    = $urandom_range(0, 9);
      mode = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
      fetch(32'h40 + 32'($urandom_range(0, 3)) * 4, $urandom_range(0, 3),
            $urandom_range(0, 3), instr_t'($urandom), mode);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Runaway guard
  initial begin
    #500000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
